iram_loader: RTL

//   Writer side of the instruction-RAM programming port (ram_ena/ram_wena/ram_indata) consumed by the fetch stage.

---
 rtl/iram_loader_pkg.sv | 34 +++
 rtl/iram_loader_if.sv | 40 ++++
 rtl/iram_loader_word_assembler.sv | 43 ++++
 rtl/iram_loader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/iram_loader_pkg.sv
//==============================================================================
// Module : iram_loader_pkg
// Brief  : Shared state encoding, error codes and framing constants.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package iram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_BYTES  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [1:0] C_ERR_NONE = 2'd0;
    localparam logic [1:0] C_ERR_LEN  = 2'd1;
    localparam logic [1:0] C_ERR_CSUM = 2'd2;

    localparam int C_BYTES_PER_WORD = 4;

    // A start pulse is only honoured outside the loading states.
    function automatic logic state_is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

`default_nettype wire

// File: rtl/iram_loader_if.sv
//==============================================================================
// Module : iram_loader_if
// Brief  : Byte-stream input, instruction-RAM write port and loader status.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface iram_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_indata;
    logic              cpu_hold;
    logic              pc_restart;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, ram_ena, ram_wena, ram_addr, ram_indata,
        input  cpu_hold, pc_restart, busy, done, err, err_code
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, ram_ena, ram_wena, ram_addr, ram_indata,
        output cpu_hold, pc_restart, busy, done, err, err_code
    );
endinterface

`default_nettype wire

// File: rtl/iram_loader_word_assembler.sv
//==============================================================================
// Module : iram_loader_word_assembler
// Brief  : Shifts bytes MSB-first into a 32-bit word and keeps a running XOR.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module iram_loader_word_assembler
    import iram_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_byte_valid,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_word,
    output logic             o_word_full,
    output logic      [7:0]  o_csum
);
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [7:0]  r_csum;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
            r_csum <= '0;
        end else if (i_byte_valid) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= {r_word[23:0], i_byte};
            r_csum <= r_csum ^ i_byte;
        end
    end

    // Flags that the byte currently being offered completes the word.
    assign o_word_full = (r_idx == 2'(C_BYTES_PER_WORD - 1));
    assign o_word      = r_word;
    assign o_csum      = r_csum;

endmodule

`default_nettype wire

// File: rtl/iram_loader.sv
//==============================================================================
// Module : iram_loader
// Brief  : Loads a framed byte stream into instruction RAM while holding the CPU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input wire logic     clk,
    input wire logic     rst,
    iram_loader_if.slave bus
);
    localparam logic [16:0] C_CAPACITY = 17'(2 ** ADDR_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_start_acc;
    logic [16:0]       w_len;
    logic [DATA_W-1:0] w_word;
    logic              w_word_full;
    logic [7:0]        w_csum;
    logic [7:0]        r_len_hi;
    logic [16:0]       r_words_left;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_err_code;
    logic              r_pc_restart;

    assign w_start_acc = bus.start && !state_is_busy(r_state);
    assign w_len       = {1'b0, r_len_hi, bus.in_data};

    iram_loader_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_acc),
        .i_byte_valid ((r_state == ST_BYTES) && bus.in_valid),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_full  (w_word_full),
        .o_csum       (w_csum)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_start_acc) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_len == 17'd0)           w_state_nxt = ST_CSUM;
                    else if (w_len > C_CAPACITY)  w_state_nxt = ST_ERR;
                    else                          w_state_nxt = ST_BYTES;
                end
            end
            ST_BYTES: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_word_full) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = (r_words_left == 17'd1) ? ST_CSUM : ST_BYTES;
            end
            ST_CSUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = (bus.in_data == w_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_hi     <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
            r_err_code   <= C_ERR_NONE;
            r_pc_restart <= 1'b0;
        end else begin
            r_pc_restart <= (r_state == ST_CSUM) && (w_state_nxt == ST_DONE);
            if (w_start_acc) begin
                r_words_left <= '0;
                r_addr       <= '0;
                r_err_code   <= C_ERR_NONE;
            end
            if ((r_state == ST_LEN_HI) && bus.in_valid) r_len_hi <= bus.in_data;
            if ((r_state == ST_LEN_LO) && bus.in_valid) begin
                r_words_left <= w_len;
                if (w_len > C_CAPACITY) r_err_code <= C_ERR_LEN;
            end
            // The last word keeps its address so a full-capacity load never wraps.
            if (r_state == ST_WRITE) begin
                r_words_left <= r_words_left - 17'd1;
                if (r_words_left != 17'd1) r_addr <= r_addr + ADDR_W'(1);
            end
            if ((r_state == ST_CSUM) && bus.in_valid && (bus.in_data != w_csum))
                r_err_code <= C_ERR_CSUM;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.ram_ena    = (r_state == ST_WRITE);
    assign bus.ram_wena   = (r_state == ST_WRITE);
    assign bus.ram_addr   = r_addr;
    assign bus.ram_indata = w_word;
    assign bus.cpu_hold   = !(r_state inside {ST_IDLE, ST_DONE});
    assign bus.pc_restart = r_pc_restart;
    assign bus.busy       = state_is_busy(r_state);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_ERR);
    assign bus.err_code   = r_err_code;

endmodule

`default_nettype wire
